// File: rtl/pio_pkg.sv
// PIO action codes and the stereo byte-order swap shared by the I2S transmit and receive paths.
package pio_pkg;

  localparam logic [5:0] PIO_NONE = 6'd0;
  localparam logic [5:0] PIO_PUSH = 6'd4;
  localparam logic [5:0] PIO_PULL = 6'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULL    = 2'd1,
    ST_CAPTURE = 2'd2
  } rx_state_e;

  // Swaps the two bytes inside each 16-bit channel; applying it twice is the identity.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[23:16], w[31:24], w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;

  assign valid   = (level != '0);
  assign pop     = rd_en && valid;
  assign rd_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_rx_drain.sv
// Drains one PIO RX FIFO into a local FWFT buffer, restoring stereo byte order.
// Define I2S_RX_STATS_EN to add the word_count / stall_count statistics outputs.
//
// state      | meaning
// IDLE       | waiting for data, enable and buffer room
// PULL       | PULL action issued to the PIO this cycle
// CAPTURE    | PIO read data valid, written into the buffer
module i2s_rx_drain
  import pio_pkg::*;
#(
  parameter int unsigned SM_INDEX    = 0,
  parameter logic [5:0]  PULL_ACTION = PIO_PULL,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [3:0]                    rx_empty,
  input  logic [31:0]                   dout,
  output logic [5:0]                    action,
  output logic [1:0]                    mindex,
  output logic [31:0]                   sample,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level
`ifdef I2S_RX_STATS_EN
  ,
  output logic [31:0]                   word_count,
  output logic [15:0]                   stall_count
`endif
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0]    SM_SEL  = 2'(SM_INDEX);
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  rx_state_e     state, state_next;
  logic          fifo_wr;
  logic [LW-1:0] occupancy;
  logic          room;
  logic          can_pull;
  logic          unused_rx_empty;

  // Only the selected machine's flag matters; the others are intentionally ignored.
  assign unused_rx_empty = ^rx_empty;

  assign mindex    = SM_SEL;
  assign occupancy = level + LW'(state != ST_IDLE);
  assign room      = (occupancy < DEPTH_L);
  assign can_pull  = enable && !rx_empty[SM_SEL] && room;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    action     = PIO_NONE;
    fifo_wr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (can_pull) state_next = ST_PULL;
      end
      ST_PULL: begin
        action     = PULL_ACTION;
        state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        fifo_wr    = 1'b1;
        state_next = can_pull ? ST_PULL : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (byte_swap(dout)),
    .rd_en   (sample_ready),
    .rd_data (sample),
    .valid   (sample_valid),
    .level   (level)
  );

`ifdef I2S_RX_STATS_EN
  logic stall;

  // A stall is a decision cycle where data is waiting but the buffer has no room.
  assign stall = enable && !rx_empty[SM_SEL] && !room && (state != ST_PULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      word_count  <= '0;
      stall_count <= '0;
    end else begin
      if (fifo_wr) word_count <= word_count + 32'd1;
      if (stall && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/i2s_rx_drain.md
I2S_RX_DRAIN -- requirements
Module: i2s_rx_drain

Interface
REQ-001 Parameter SM_INDEX, default 0: PIO state machine whose RX FIFO is drained.
REQ-002 Parameter PULL_ACTION, default 5: PIO action code that pops one word from the selected RX FIFO.
REQ-003 Parameter FIFO_DEPTH, default 4: output buffer depth in words; power of two, 2..16.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  draining permitted while high.
REQ-007 rx_empty  input  4  PIO RX-FIFO-empty flags, one per state machine.
REQ-008 dout  input  32  PIO read data; valid exactly one cycle after a PULL action.
REQ-009 action  output  6  PIO action code; 0 = none.
REQ-010 mindex  output  2  PIO machine select; constant SM_INDEX.
REQ-011 sample  output  32  stereo sample {L[15:0], R[15:0]}, byte order restored.
REQ-012 sample_valid  output  1  sample holds valid data.
REQ-013 sample_ready  input  1  consumer accepts sample this cycle when high together with sample_valid.
REQ-014 level  output  $clog2(FIFO_DEPTH)+1  words currently buffered.

Function
REQ-015 States: IDLE, PULL, CAPTURE.
REQ-016 IDLE -> PULL when enable=1, rx_empty[SM_INDEX]=0, and level plus in-flight words < FIFO_DEPTH.
REQ-017 In PULL, action=PULL_ACTION for exactly one cycle; the next state is always CAPTURE.
REQ-018 In CAPTURE, action=0; dout is written to the buffer; the next state is PULL if the IDLE->PULL condition still holds, otherwise IDLE.
REQ-019 Maximum throughput is one word per 2 cycles; no two consecutive cycles carry a PULL action.
REQ-020 Stored word = {dout[23:16], dout[31:24], dout[7:0], dout[15:8]}, the inverse of the transmit-side byte swap.
REQ-021 Output stream is first-word-fall-through: sample_valid=1 whenever level>0, and sample shows the oldest word.
REQ-022 A write and a pop in the same cycle are both performed and leave level unchanged.
REQ-023 A pop with level=0 is ignored.
REQ-024 A write never occurs with level=FIFO_DEPTH; the admission rule of REQ-016 guarantees this.
REQ-025 Pointers wrap modulo FIFO_DEPTH.
REQ-026 Deasserting enable during PULL or CAPTURE completes that word, then the block goes to IDLE; buffered data is kept.
REQ-027 mindex is held at SM_INDEX in every cycle, including during reset.

Reset
REQ-028 On reset: state=IDLE, action=0, level=0, pointers=0, sample_valid=0, sample=0.
REQ-029 Reset mid-transfer discards any in-flight word and all buffered words, and issues no further PULL.

Configuration
REQ-030 With I2S_RX_STATS_EN defined, the block adds outputs word_count (32 bits), incremented on each buffer write, and stall_count (16 bits), incremented on each cycle where enable=1, rx_empty[SM_INDEX]=0, and the IDLE->PULL condition fails because the buffer is full.
REQ-031 word_count wraps; stall_count saturates at 0xFFFF; both clear on reset.
REQ-032 Without I2S_RX_STATS_EN, neither port nor counter exists and behaviour is otherwise identical.

Structure
REQ-033 Shared package pio_pkg holds the PIO action code constants (NONE=0, PUSH=4, PULL=5) and the byte-swap function shared with the transmit path.
REQ-034 The output buffer is a separate sub-module, sync_fifo, parameterised by width and depth.

Verification
REQ-035 Reset, then enable=1, rx_empty[0]=0, dout=0x11223344, sample_ready=1 -> PULL one cycle after enable, sample=0x22114433 with sample_valid the cycle after CAPTURE.
REQ-036 rx_empty[0] held 0, sample_ready=0, FIFO_DEPTH=4 -> exactly 4 PULL actions, then level=4 and action stays 0; with STATS, stall_count increments every cycle after that.
REQ-037 Full buffer, then sample_ready=1 for 1 cycle -> level=3, and a single PULL follows.
REQ-038 Simultaneous CAPTURE write and consumer pop at level=2 -> level stays 2 and word order is preserved.
REQ-039 Reset asserted in the PULL cycle -> no buffer write, level=0, sample_valid=0 the cycle after reset.
REQ-040 rx_empty toggling 0/1 every cycle over 1000 cycles -> output word sequence equals the byte-swapped input sequence, with no loss or duplication.
